// File: rtl/wf68k30l_bus_arbiter.sv
// wf68k30l_bus_arbiter: MC68030-style bus arbitration, BRn/BGACKn sync, BGn issue and core cycle gating.
module wf68k30l_bus_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BRn,
  input  logic       BGACKn,
  input  logic       CORE_REQ,
  input  logic       CYCLE_ACTIVE,
  input  logic       RMC_LOCK,
  output logic       BGn,
  output logic       BUS_EN,
  output logic       CORE_GO,
  output logic [2:0] ARB_STATE
);
  localparam logic [2:0] OWN      = 3'd0;
  localparam logic [2:0] WAIT_END = 3'd1;
  localparam logic [2:0] GRANT    = 3'd2;
  localparam logic [2:0] EXTERNAL = 3'd3;
  localparam logic [2:0] TURN     = 3'd4;
  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);
  logic [SYNC_STAGES-1:0] br_sync_q, bgack_sync_q;
  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic br_s, bgack_s, core_free;
  assign br_s      = br_sync_q[SYNC_STAGES-1];
  assign bgack_s   = bgack_sync_q[SYNC_STAGES-1];
  assign core_free = !CYCLE_ACTIVE && !RMC_LOCK;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      br_sync_q    <= '1;
      bgack_sync_q <= '1;
      state_q      <= OWN;
      cnt_q        <= '0;
    end else begin
      br_sync_q    <= {br_sync_q[SYNC_STAGES-2:0], BRn};
      bgack_sync_q <= {bgack_sync_q[SYNC_STAGES-2:0], BGACKn};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
    end
  end
  // Release happens only between cycles and outside locked RMC sequences.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      OWN:      if (!br_s) state_d = core_free ? GRANT : WAIT_END;
      WAIT_END: state_d = br_s ? OWN : core_free ? GRANT : WAIT_END;
      GRANT: begin
        if (!bgack_s) state_d = EXTERNAL;
        else if (br_s) begin
          state_d = TURN;
          cnt_d   = TURN_LOAD;
        end
      end
      EXTERNAL: begin
        if (bgack_s) begin
          state_d = TURN;
          cnt_d   = TURN_LOAD;
        end
      end
      TURN: begin
        if (cnt_q == 4'd0) state_d = br_s ? OWN : GRANT;
        else cnt_d = cnt_q - 4'd1;
      end
      default: state_d = OWN;
    endcase
  end
  assign BGn       = state_q != GRANT;
  assign BUS_EN    = state_q == OWN || state_q == WAIT_END;
  assign CORE_GO   = state_q == OWN && CORE_REQ && br_s;
  assign ARB_STATE = state_q;
endmodule

// File: tb/tb_wf68k30l_bus_arbiter.sv
// tb_wf68k30l_bus_arbiter: scoreboard-driven scenario bench for the bus arbiter (SYNC_STAGES=2, TURN_CYCLES=1).
module tb_wf68k30l_bus_arbiter;
  logic clk = 1'b0;
  logic rst, br_n, bgack_n, core_req, cycle_active, rmc_lock;
  logic bg_n, bus_en, core_go;
  logic [2:0] arb_state;
  int checks = 0;
  int failures = 0;
  localparam int K_BGN = 0, K_BUSEN = 1, K_STATE = 2, K_GO = 3;
  typedef struct {
    int e;
    int k;
    logic [2:0] v;
    string n;
  } exp_t;
  exp_t sb[$];
  wf68k30l_bus_arbiter #(.SYNC_STAGES(2), .TURN_CYCLES(1)) dut (
    .CLK(clk), .RESET(rst), .BRn(br_n), .BGACKn(bgack_n), .CORE_REQ(core_req),
    .CYCLE_ACTIVE(cycle_active), .RMC_LOCK(rmc_lock), .BGn(bg_n), .BUS_EN(bus_en),
    .CORE_GO(core_go), .ARB_STATE(arb_state)
  );
  always #5 clk = ~clk;
  function automatic logic [2:0] obs(int k);
    return k == K_BGN ? {2'b0, bg_n} : k == K_BUSEN ? {2'b0, bus_en} :
           k == K_STATE ? arb_state : {2'b0, core_go};
  endfunction
  task automatic push(int e, int k, logic [2:0] v, string n);
    sb.push_back('{e, k, v, n});
  endtask
  task automatic apply_reset();
    rst = 1'b1; br_n = 1'b1; bgack_n = 1'b1; core_req = 1'b0; cycle_active = 1'b0; rmc_lock = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic test_reset();
    exp_t x;
    apply_reset();
    push(0, K_STATE, 3'd0, "rst_state");
    push(0, K_BGN, 3'd1, "rst_bgn");
    push(0, K_BUSEN, 3'd1, "rst_busen");
    push(0, K_GO, 3'd0, "rst_go");
    while (sb.size() > 0) begin
      x = sb.pop_front();
      checks++;
      if (obs(x.k) !== x.v) begin
        failures++;
        $display("FAIL %s e=%0d got=%0d exp=%0d", x.n, x.e, obs(x.k), x.v);
      end
    end
  endtask
  task automatic test_idle_grant();
    exp_t x;
    apply_reset();
    core_req = 1'b1;
    push(9, K_GO, 3'd1, "idle_go_before");
    push(11, K_GO, 3'd0, "idle_go_brwins");
    push(11, K_STATE, 3'd0, "idle_state_own");
    push(12, K_BGN, 3'd0, "idle_bgn_low");
    push(12, K_BUSEN, 3'd0, "idle_busen_low");
    push(16, K_STATE, 3'd2, "idle_still_grant");
    push(17, K_BGN, 3'd1, "idle_bgn_rel");
    push(17, K_STATE, 3'd3, "idle_external");
    push(32, K_STATE, 3'd4, "idle_turn");
    push(32, K_BUSEN, 3'd0, "idle_turn_busen");
    push(33, K_BUSEN, 3'd1, "idle_busen_back");
    push(33, K_STATE, 3'd0, "idle_own_back");
    for (int e = 1; e <= 34; e++) begin
      br_n = !(e >= 10 && e <= 16);
      bgack_n = !(e >= 15 && e <= 29);
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].e == e) begin
        x = sb.pop_front();
        checks++;
        if (obs(x.k) !== x.v) begin
          failures++;
          $display("FAIL %s e=%0d got=%0d exp=%0d", x.n, e, obs(x.k), x.v);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL idle_leftover got=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask
  task automatic test_mid_cycle();
    exp_t x;
    apply_reset();
    core_req = 1'b1;
    push(7, K_GO, 3'd0, "mid_go_off");
    push(8, K_STATE, 3'd1, "mid_wait_end");
    push(8, K_BUSEN, 3'd1, "mid_busen_held");
    push(10, K_GO, 3'd0, "mid_go_wait");
    push(12, K_STATE, 3'd1, "mid_wait_12");
    push(12, K_BUSEN, 3'd1, "mid_busen_12");
    push(12, K_BGN, 3'd1, "mid_bgn_12");
    push(13, K_BGN, 3'd0, "mid_bgn_low");
    push(13, K_STATE, 3'd2, "mid_grant");
    for (int e = 1; e <= 14; e++) begin
      cycle_active = e >= 5 && e <= 12;
      br_n = e < 6;
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].e == e) begin
        x = sb.pop_front();
        checks++;
        if (obs(x.k) !== x.v) begin
          failures++;
          $display("FAIL %s e=%0d got=%0d exp=%0d", x.n, e, obs(x.k), x.v);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL mid_leftover got=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask
  task automatic test_rmc_lock();
    exp_t x;
    apply_reset();
    push(7, K_STATE, 3'd1, "rmc_wait_end");
    push(10, K_BGN, 3'd1, "rmc_bgn_10");
    push(15, K_BGN, 3'd1, "rmc_bgn_15");
    push(20, K_BGN, 3'd1, "rmc_bgn_20");
    push(20, K_STATE, 3'd1, "rmc_state_20");
    push(21, K_BGN, 3'd0, "rmc_bgn_low");
    push(21, K_STATE, 3'd2, "rmc_grant");
    for (int e = 1; e <= 22; e++) begin
      rmc_lock = e >= 4 && e <= 20;
      cycle_active = (e >= 4 && e <= 20) ? e[0] : 1'b0;
      br_n = e < 5;
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].e == e) begin
        x = sb.pop_front();
        checks++;
        if (obs(x.k) !== x.v) begin
          failures++;
          $display("FAIL %s e=%0d got=%0d exp=%0d", x.n, e, obs(x.k), x.v);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL rmc_leftover got=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask
  task automatic test_withdrawn();
    exp_t x;
    apply_reset();
    push(12, K_STATE, 3'd2, "wd_grant");
    push(14, K_STATE, 3'd2, "wd_grant_hold");
    push(15, K_STATE, 3'd4, "wd_turn");
    push(15, K_BGN, 3'd1, "wd_bgn_rel");
    push(15, K_BUSEN, 3'd0, "wd_turn_busen");
    push(16, K_STATE, 3'd0, "wd_own");
    push(16, K_BUSEN, 3'd1, "wd_busen_back");
    for (int e = 1; e <= 17; e++) begin
      br_n = !(e >= 10 && e <= 12);
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].e == e) begin
        x = sb.pop_front();
        checks++;
        if (obs(x.k) !== x.v) begin
          failures++;
          $display("FAIL %s e=%0d got=%0d exp=%0d", x.n, e, obs(x.k), x.v);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL wd_leftover got=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask
  task automatic test_back_to_back();
    exp_t x;
    apply_reset();
    core_req = 1'b1;
    push(5, K_STATE, 3'd2, "b2b_grant1");
    for (int e = 4; e <= 20; e++) push(e, K_GO, 3'd0, "b2b_go_off");
    push(10, K_STATE, 3'd3, "b2b_external");
    push(17, K_STATE, 3'd4, "b2b_turn");
    push(18, K_STATE, 3'd2, "b2b_grant2");
    push(18, K_BGN, 3'd0, "b2b_bgn2");
    push(18, K_BUSEN, 3'd0, "b2b_busen_off");
    sb.sort with (item.e);
    for (int e = 1; e <= 20; e++) begin
      br_n = e < 3;
      bgack_n = !(e >= 8 && e <= 14);
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].e == e) begin
        x = sb.pop_front();
        checks++;
        if (obs(x.k) !== x.v) begin
          failures++;
          $display("FAIL %s e=%0d got=%0d exp=%0d", x.n, e, obs(x.k), x.v);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_leftover got=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask
  task automatic test_reset_external();
    exp_t x;
    apply_reset();
    push(12, K_STATE, 3'd3, "rx_external");
    push(13, K_STATE, 3'd0, "rx_state_own");
    push(13, K_BGN, 3'd1, "rx_bgn");
    push(13, K_BUSEN, 3'd1, "rx_busen");
    push(14, K_STATE, 3'd0, "rx_state_hold");
    push(14, K_BUSEN, 3'd1, "rx_busen_hold");
    for (int e = 1; e <= 14; e++) begin
      br_n = e < 3;
      bgack_n = e < 8;
      rst = e == 13;
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].e == e) begin
        x = sb.pop_front();
        checks++;
        if (obs(x.k) !== x.v) begin
          failures++;
          $display("FAIL %s e=%0d got=%0d exp=%0d", x.n, e, obs(x.k), x.v);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL rx_leftover got=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask
  initial begin
    test_reset();
    test_idle_grant();
    test_mid_cycle();
    test_rmc_lock();
    test_withdrawn();
    test_back_to_back();
    test_reset_external();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
